// File: rtl/net_activity_monitor_if.sv
// Observation interface for net_activity_monitor.
//   master: drives the monitored net sample_in, the sample enable en and the soft clear clr;
//           receives done, toggle_cnt, rare_flag, signature and busy.
//   slave : the monitor side of the same signals.
interface net_activity_monitor_if #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned MISR_W = 16
);
  logic              sample_in;
  logic              en;
  logic              clr;
  logic              done;
  logic [CNT_W-1:0]  toggle_cnt;
  logic              rare_flag;
  logic [MISR_W-1:0] signature;
  logic              busy;

  modport master (
    output sample_in, en, clr,
    input  done, toggle_cnt, rare_flag, signature, busy
  );

  modport slave (
    input  sample_in, en, clr,
    output done, toggle_cnt, rare_flag, signature, busy
  );
endinterface

// File: rtl/net_activity_monitor.sv
// Activity monitor for a single-bit subcircuit output net.
// Over windows of WINDOW enabled cycles it counts value transitions (saturating) and compacts
// the sampled stream into a MISR signature, then reports both plus a rare-activity flag.
// Ports:
//   I1470_clk  clock, rising edge
//   I1477_rst  synchronous reset, active low
//   mon        slave side of net_activity_monitor_if:
//                sample_in  monitored net
//                en         sample enable (window pauses while low)
//                clr        synchronous soft clear, keeps latched results
//                done       one-cycle pulse in the report cycle
//                toggle_cnt latched toggle count of the last window
//                rare_flag  latched toggle_cnt < RARE_TH
//                signature  latched MISR value of the last window
//                busy       high while a window is being collected
module net_activity_monitor #(
  parameter int unsigned       CNT_W     = 8,
  parameter int unsigned       WIN_W     = 8,
  parameter int unsigned       WINDOW    = 200,
  parameter int unsigned       RARE_TH   = 2,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(16'hB400)
) (
  input logic                   I1470_clk,
  input logic                   I1477_rst,
  net_activity_monitor_if.slave mon
);

  typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

  state_e            state_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  tog_cnt_q;
  logic [MISR_W-1:0] misr_q;
  logic              prev_q;
  logic              prev_vld_q;

  logic              done_q;
  logic              busy_q;
  logic [CNT_W-1:0]  toggle_cnt_q;
  logic              rare_flag_q;
  logic [MISR_W-1:0] signature_q;

  logic [MISR_W-1:0] misr_step;
  logic              tog_inc;
  logic [CNT_W-1:0]  tog_next;
  logic [WIN_W-1:0]  win_next;
  logic              win_end;

  // misr_q is zero in IDLE, so the same step also seeds the first sample of a window.
  assign misr_step = (misr_q << 1) ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ {{(MISR_W-1){1'b0}}, mon.sample_in};

  assign tog_inc  = prev_vld_q && (mon.sample_in != prev_q) && !(&tog_cnt_q);
  assign tog_next = tog_cnt_q + CNT_W'(tog_inc);
  assign win_next = win_cnt_q + WIN_W'(1);
  assign win_end  = (win_next == WIN_W'(WINDOW));

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state_q      <= StIdle;
      win_cnt_q    <= '0;
      tog_cnt_q    <= '0;
      misr_q       <= '0;
      prev_q       <= 1'b0;
      prev_vld_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      toggle_cnt_q <= '0;
      rare_flag_q  <= 1'b0;
      signature_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (mon.clr) begin
        // Soft clear drops the window in flight; a coincident window end is not reported.
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        win_cnt_q  <= '0;
        tog_cnt_q  <= '0;
        misr_q     <= '0;
        prev_q     <= 1'b0;
        prev_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (mon.en) begin
              state_q    <= StRun;
              busy_q     <= 1'b1;
              win_cnt_q  <= WIN_W'(1);
              misr_q     <= misr_step;
              prev_q     <= mon.sample_in;
              prev_vld_q <= 1'b1;
            end
          end
          StRun: begin
            if (mon.en) begin
              prev_q <= mon.sample_in;
              if (win_end) begin
                // Results are latched on entry so they are valid together with done;
                // the working state restarts while prev carries across the boundary.
                state_q      <= StReport;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                toggle_cnt_q <= tog_next;
                rare_flag_q  <= (32'(tog_next) < RARE_TH);
                signature_q  <= misr_step;
                win_cnt_q    <= '0;
                tog_cnt_q    <= '0;
                misr_q       <= '0;
              end else begin
                win_cnt_q <= win_next;
                tog_cnt_q <= tog_next;
                misr_q    <= misr_step;
              end
            end
          end
          StReport: begin
            // sample_in is not taken in the report cycle.
            if (mon.en) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              state_q    <= StIdle;
              prev_vld_q <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.done       = done_q;
  assign mon.busy       = busy_q;
  assign mon.toggle_cnt = toggle_cnt_q;
  assign mon.rare_flag  = rare_flag_q;
  assign mon.signature  = signature_q;

endmodule

// File: tb/tb_net_activity_monitor.sv
module tb_net_activity_monitor;

  localparam int unsigned WinA  = 200;
  localparam int unsigned WinB  = 40;
  localparam int unsigned CntA  = 8;
  localparam int unsigned CntB  = 4;
  localparam logic [15:0] Poly  = 16'hB400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  bit   alt = 1'b0;
  bit   rnd = 1'b0;

  always #5 clk = ~clk;

  net_activity_monitor_if #(.CNT_W(CntA), .MISR_W(16)) ifa ();
  net_activity_monitor_if #(.CNT_W(CntB), .MISR_W(16)) ifb ();

  assign ifa.sample_in = sample;
  assign ifa.en        = en;
  assign ifa.clr       = clr;
  assign ifb.sample_in = sample;
  assign ifb.en        = en;
  assign ifb.clr       = clr;

  net_activity_monitor #(
    .CNT_W(CntA), .WIN_W(8), .WINDOW(WinA), .RARE_TH(2), .MISR_W(16), .MISR_POLY(Poly)
  ) dut_a (
    .I1470_clk(clk),
    .I1477_rst(rst),
    .mon      (ifa)
  );

  net_activity_monitor #(
    .CNT_W(CntB), .WIN_W(8), .WINDOW(WinB), .RARE_TH(2), .MISR_W(16), .MISR_POLY(Poly)
  ) dut_b (
    .I1470_clk(clk),
    .I1477_rst(rst),
    .mon      (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] misr_push(logic [15:0] m, bit s);
    return (m << 1) ^ (m[15] ? Poly : 16'h0) ^ {15'h0, s};
  endfunction

  // Reference model: keeps the enabled samples of the current window and evaluates the
  // window only when it is complete.
  bit          samp      [2][256];
  int unsigned nsamp     [2];
  bit          start_pv  [2];
  bit          start_p   [2];
  bit          have_prev [2];
  bit          last      [2];
  bit          active    [2];
  bit          report    [2];
  bit          exp_done  [2];
  bit          exp_busy  [2];
  int unsigned exp_tog   [2];
  bit          exp_rare  [2];
  logic [15:0] exp_sig   [2];

  task automatic model_step(input int k);
    int unsigned wlen;
    int unsigned cmax;
    int unsigned t;
    bit          pv;
    bit          p;
    logic [15:0] m;
    wlen = (k == 0) ? WinA : WinB;
    cmax = (k == 0) ? 255 : 15;
    if (!rst) begin
      nsamp[k] = 0; have_prev[k] = 0; last[k] = 0; active[k] = 0; report[k] = 0;
      exp_done[k] = 0; exp_tog[k] = 0; exp_rare[k] = 0; exp_sig[k] = 16'h0;
    end else if (clr) begin
      nsamp[k] = 0; have_prev[k] = 0; last[k] = 0; active[k] = 0; report[k] = 0;
      exp_done[k] = 0;
    end else if (report[k]) begin
      report[k] = 0; exp_done[k] = 0; active[k] = en;
      if (!en) have_prev[k] = 0;
    end else begin
      exp_done[k] = 0;
      if (en) begin
        if (nsamp[k] == 0) begin
          start_pv[k] = have_prev[k];
          start_p[k]  = last[k];
        end
        samp[k][nsamp[k]] = sample;
        nsamp[k]++;
        have_prev[k] = 1; last[k] = sample; active[k] = 1;
        if (nsamp[k] == wlen) begin
          t = 0; pv = start_pv[k]; p = start_p[k]; m = 16'h0;
          for (int i = 0; i < int'(wlen); i++) begin
            if (pv && samp[k][i] != p) t++;
            p = samp[k][i]; pv = 1;
            m = misr_push(m, samp[k][i]);
          end
          exp_tog[k]  = (t > cmax) ? cmax : t;
          exp_rare[k] = exp_tog[k] < 2;
          exp_sig[k]  = m;
          exp_done[k] = 1; report[k] = 1; nsamp[k] = 0;
        end
      end
    end
    exp_busy[k] = active[k] && !report[k];
  endtask

  int          done_cyc_q[$];
  int unsigned done_tog_q[$];
  logic [15:0] done_sig_q[$];

  task automatic step();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    check("a_done",  ifa.done,       exp_done[0]);
    check("a_busy",  ifa.busy,       exp_busy[0]);
    check("a_tog",   ifa.toggle_cnt, exp_tog[0]);
    check("a_rare",  ifa.rare_flag,  exp_rare[0]);
    check("a_sig",   ifa.signature,  exp_sig[0]);
    check("b_done",  ifb.done,       exp_done[1]);
    check("b_busy",  ifb.busy,       exp_busy[1]);
    check("b_tog",   ifb.toggle_cnt, exp_tog[1]);
    check("b_rare",  ifb.rare_flag,  exp_rare[1]);
    check("b_sig",   ifb.signature,  exp_sig[1]);
    if (ifa.done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_tog_q.push_back(ifa.toggle_cnt);
      done_sig_q.push_back(ifa.signature);
    end
    if (alt) sample = ~sample;
    if (rnd) sample = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    rst = 0; en = 0; clr = 0; alt = 0; rnd = 0; sample = 0;
    repeat (n) step();
    rst = 1;
    done_cyc_q.delete(); done_tog_q.delete(); done_sig_q.delete();
  endtask

  // Steps until DUT A reports, at most max_cyc edges; at = -1 when no report came.
  task automatic run_until_done(input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (ifa.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  int          en_start;
  int          at;
  int          clr_cyc;
  int unsigned saved_tog;
  logic [15:0] saved_sig;
  logic [15:0] sw_sig;

  initial begin
    // Toggle window: alternating input, two full windows.
    do_reset(3);
    check("rst_done", ifa.done, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_tog",  ifa.toggle_cnt, 0);
    check("rst_sig",  ifa.signature, 0);
    en = 1; sample = 0; alt = 1; en_start = cyc + 1;
    repeat (420) step();
    check("alt_ndone", done_cyc_q.size(), 2);
    // Period number counting the first enabled cycle as cycle 1.
    check("alt_done_cycle", done_cyc_q[0] - en_start + 2, 201);
    check("alt_tog1", done_tog_q[0], 199);
    check("alt_tog2", done_tog_q[1], 199);
    check("alt_rare", ifa.rare_flag, 0);
    check("sat_tog", ifb.toggle_cnt, 15);

    // Constant zero input.
    do_reset(2);
    en = 1; sample = 0;
    repeat (410) step();
    check("const_ndone", done_cyc_q.size(), 2);
    check("const_tog",  ifa.toggle_cnt, 0);
    check("const_rare", ifa.rare_flag, 1);
    check("const_sig",  ifa.signature, 16'h0000);

    // Pause: one toggle at enabled cycle 50, en low for 30 cycles mid-window.
    do_reset(2);
    en_start = cyc + 1;
    for (int i = 1; i <= 100; i++) begin
      en = 1; sample = (i >= 50) ? 1'b0 : 1'b1;
      step();
    end
    en = 0;
    repeat (30) step();
    en = 1;
    run_until_done(300, at);
    check("pause_done_cycle", at - en_start + 2, 231);
    check("pause_tog",  ifa.toggle_cnt, 1);
    check("pause_rare", ifa.rare_flag, 1);
    sw_sig = 16'h0;
    for (int i = 1; i <= 200; i++) sw_sig = misr_push(sw_sig, (i < 50));
    check("pause_sig", ifa.signature, sw_sig);

    // clr at enabled cycle 120 of window 2.
    do_reset(2);
    en = 1; sample = 0; alt = 1;
    repeat (320) step();
    saved_tog = done_tog_q[0];
    saved_sig = done_sig_q[0];
    check("clr_ndone", done_cyc_q.size(), 1);
    clr = 1;
    step();
    clr = 0;
    clr_cyc = cyc;
    check("clr_busy", ifa.busy, 0);
    check("clr_done", ifa.done, 0);
    check("clr_tog",  ifa.toggle_cnt, saved_tog);
    check("clr_sig",  ifa.signature, saved_sig);
    run_until_done(300, at);
    check("clr_redone_gap", at + 1 - clr_cyc, WinA + 1);

    // Reset mid-RUN.
    do_reset(2);
    en = 1; rnd = 1;
    repeat (250) step();
    rst = 0;
    step();
    check("mrst_done", ifa.done, 0);
    check("mrst_busy", ifa.busy, 0);
    check("mrst_tog",  ifa.toggle_cnt, 0);
    check("mrst_rare", ifa.rare_flag, 0);
    check("mrst_sig",  ifa.signature, 0);
    rst = 1;

    // clr exactly in the cycle that takes the WINDOW-th sample of window 2.
    done_cyc_q.delete(); done_tog_q.delete(); done_sig_q.delete();
    repeat (400) step();
    check("cclr_ndone", done_cyc_q.size(), 1);
    saved_tog = ifa.toggle_cnt;
    saved_sig = ifa.signature;
    clr = 1;
    step();
    clr = 0;
    check("cclr_done", ifa.done, 0);
    check("cclr_busy", ifa.busy, 0);
    check("cclr_tog",  ifa.toggle_cnt, saved_tog);
    check("cclr_sig",  ifa.signature, saved_sig);
    en = 0;
    step();
    check("cclr_done2", ifa.done, 0);

    // Randomized traffic against the model.
    rnd = 0;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 299) == 0);
      rst = !($urandom_range(0, 999) == 0);
      if ((i / 500) % 2 == 0) sample = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 59) == 0) sample = ~sample;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
